sha3_pad_tx: RTL

Transmit-side feeder for `perm_blk`. Accepts a byte-counted 64-bit message stream, applies SHA-3 pad10*1 padding with the `0x06` domain suffix, and emits complete 25-lane states with `firstout` marking lane 0. Lanes go out in `x + 5*y` order over the same push/stop handshake that `perm_blk` accepts on its input. The rate lanes carry message and padding; the capacity lanes are zero. Chaining XOR for multi-block messages is done downstream.

---
 rtl/perm_pkg.sv | 29 ++
 rtl/sha3_pad_tx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/perm_pkg.sv
// rtl/perm_pkg.sv - shared lane/state definitions and the pad10*1 lane helper
package perm_pkg;

  localparam int LANE_W = 64;
  localparam int NLANES = 25;

  typedef enum logic [1:0] {DATA, PADL, ZERO, CAP} state_e;

  // Keeps bytes below bcnt, writes dsuffix at byte bcnt, optionally closes the rate block.
  function automatic logic [LANE_W-1:0] pad_lane(input logic [LANE_W-1:0] din,
                                                 input logic [3:0]        bcnt,
                                                 input logic              is_last_rate,
                                                 input logic [7:0]        dsuffix);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < bcnt) begin
        r[8*k +: 8] = din[8*k +: 8];
      end else if (4'(k) == bcnt) begin
        r[8*k +: 8] = dsuffix;
      end
    end
    if (is_last_rate) begin
      r[LANE_W-1 -: 8] = r[LANE_W-1 -: 8] | 8'h80;
    end
    return r;
  endfunction

endpackage

// File: rtl/sha3_pad_tx.sv
// rtl/sha3_pad_tx.sv - pads a byte-counted word stream into 25-lane SHA-3 states
module sha3_pad_tx
  import perm_pkg::*;
#(
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DSUFFIX    = 8'h06
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pushin,
  output logic              stopin,
  input  logic              lastin,
  input  logic [3:0]        bcntin,
  input  logic [LANE_W-1:0] din,
  output logic              pushout,
  input  logic              stopout,
  output logic              firstout,
  output logic              lastout,
  output logic [LANE_W-1:0] dout
);

  localparam logic [4:0]        LAST_RATE = 5'(RATE_LANES - 1);
  localparam logic [4:0]        LAST_LANE = 5'(NLANES - 1);
  localparam logic [LANE_W-1:0] PAD_END   = {8'h80, {(LANE_W-8){1'b0}}};
  localparam logic [LANE_W-1:0] PAD_START = {{(LANE_W-8){1'b0}}, DSUFFIX};

  state_e            state_q, state_d;
  logic [4:0]        lc_q, lc_d;
  logic              pad_q, pad_d;
  logic              pend_q, pend_d;
  logic              pushout_q, pushout_d;
  logic              firstout_q, firstout_d;
  logic              lastout_q, lastout_d;
  logic [LANE_W-1:0] dout_q, dout_d;

  logic              can_load, accept, illegal, eff_last, short_word;
  logic              at_last_rate, at_last_lane;
  logic              load, lane_pad;
  logic [LANE_W-1:0] lane;

  assign stopin       = (pushout_q & stopout) | (state_q != DATA);
  assign can_load     = ~pushout_q | ~stopout;
  assign accept       = pushin & ~stopin;
  assign illegal      = (bcntin > 4'd8) | ((bcntin < 4'd8) & ~lastin);
  assign eff_last     = lastin | illegal;
  assign short_word   = ~illegal & (bcntin < 4'd8);
  assign at_last_rate = (lc_q == LAST_RATE);
  assign at_last_lane = (lc_q == LAST_LANE);

  always_comb begin
    state_d    = state_q;
    lc_d       = lc_q;
    pad_d      = pad_q;
    pend_d     = pend_q;
    pushout_d  = pushout_q & stopout;
    firstout_d = firstout_q;
    lastout_d  = lastout_q;
    dout_d     = dout_q;
    load       = 1'b0;
    lane       = '0;
    lane_pad   = 1'b0;

    unique case (state_q)
      DATA: begin
        if (accept) begin
          load = 1'b1;
          if (short_word) begin
            lane     = pad_lane(din, bcntin, at_last_rate, DSUFFIX);
            lane_pad = 1'b1;
            state_d  = at_last_rate ? CAP : ZERO;
          end else begin
            lane = din;
            // A full last word in the final rate lane pushes the pad into a fresh state.
            if (eff_last && at_last_rate) begin
              state_d = CAP;
              pend_d  = 1'b1;
            end else if (eff_last) begin
              state_d = PADL;
            end else begin
              state_d = at_last_rate ? CAP : DATA;
            end
          end
        end
      end
      PADL: begin
        if (can_load) begin
          load     = 1'b1;
          lane     = PAD_START | (at_last_rate ? PAD_END : '0);
          lane_pad = 1'b1;
          state_d  = at_last_rate ? CAP : ZERO;
        end
      end
      ZERO: begin
        if (can_load) begin
          load    = 1'b1;
          lane    = at_last_rate ? PAD_END : '0;
          state_d = at_last_rate ? CAP : ZERO;
        end
      end
      CAP: begin
        if (can_load) begin
          load = 1'b1;
          if (at_last_lane) begin
            state_d = pend_q ? PADL : DATA;
            pend_d  = 1'b0;
          end
        end
      end
      default: state_d = DATA;
    endcase

    if (load) begin
      pushout_d  = 1'b1;
      dout_d     = lane;
      firstout_d = (lc_q == 5'd0);
      lastout_d  = at_last_lane & (pad_q | lane_pad);
      lc_d       = at_last_lane ? 5'd0 : lc_q + 5'd1;
      pad_d      = at_last_lane ? 1'b0 : (pad_q | lane_pad);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DATA;
      lc_q       <= 5'd0;
      pad_q      <= 1'b0;
      pend_q     <= 1'b0;
      pushout_q  <= 1'b0;
      firstout_q <= 1'b0;
      lastout_q  <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      lc_q       <= lc_d;
      pad_q      <= pad_d;
      pend_q     <= pend_d;
      pushout_q  <= pushout_d;
      firstout_q <= firstout_d;
      lastout_q  <= lastout_d;
      dout_q     <= dout_d;
    end
  end

  assign pushout  = pushout_q;
  assign firstout = firstout_q;
  assign lastout  = lastout_q;
  assign dout     = dout_q;

endmodule
